array_stream_collector: RTL and testbench

- Receive side for the parallel W-bit element array used by the array-reduction datapath.
- Accepts elements one per cycle over a valid/ready stream and packs them into an N-element array.
- Presents the packed array together with its element count, sum and maximum through a valid/ready output handshake.
- Sits between a serial source (DMA or UART unpacker) and the combinational array consumer.

---
 rtl/array_pkg.sv | 24 ++
 rtl/array_acc_unit.sv | 30 +++
 rtl/array_stream_collector.sv | 115 +++++++++++
 tb/tb_array_stream_collector.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/array_pkg.sv
// Shared definitions for the array collector: FSM encoding and width helpers.
package array_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Sum width that holds n elements of w bits without wrapping.
    function automatic int sum_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

    // Length field width able to express 0..n.
    function automatic int len_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Slot index width addressing 0..n-1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/array_acc_unit.sv
// Registered running sum and maximum of an unsigned element stream.
module array_acc_unit #(
    parameter int W     = 8,
    parameter int SUM_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [W-1:0]     din,
    output logic [SUM_W-1:0] acc_sum,
    output logic [W-1:0]     acc_max
);

    // Accumulate on enable; clear wins so a released frame starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum <= '0;
            acc_max <= '0;
        end else if (clr) begin
            acc_sum <= '0;
            acc_max <= '0;
        end else if (en) begin
            acc_sum <= acc_sum + SUM_W'(din);
            if (din > acc_max)
                acc_max <= din;
        end
    end

endmodule

// File: rtl/array_stream_collector.sv
// Packs a serial valid/ready element stream into an N-element array and
// presents it with length, sum, maximum and truncation flag.
module array_stream_collector
    import array_pkg::*;
#(
    parameter int  W     = 8,
    parameter int  N     = 8,
    localparam int SUM_W = sum_width(W, N),
    localparam int LEN_W = len_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*W-1:0]   out_array,
    output logic [LEN_W-1:0] out_len,
    output logic [SUM_W-1:0] out_sum,
    output logic [W-1:0]     out_max,
    output logic             out_trunc
);

    localparam int              IDX_W    = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     slot [N];
    logic             accept;
    logic             close;
    logic             release_frame;

    // Data is only sampled on a real accept, so X on an idle bus never lands in state.
    assign accept        = in_valid & in_ready;
    assign close         = accept & (in_last | (idx == LAST_IDX));
    assign release_frame = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    // Next state: close a frame into HOLD, leave HOLD on the consumer handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (close)     state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = COLLECT;
            default:                state_nxt = COLLECT;
        endcase
    end

    // Handshake outputs decoded from state; no bypass between the two sides.
    always_comb begin
        in_ready  = (state == COLLECT);
        out_valid = (state == HOLD);
    end

    // Slot index, frame length and truncation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            out_len   <= '0;
            out_trunc <= 1'b0;
        end else if (release_frame) begin
            idx       <= '0;
            out_len   <= '0;
            out_trunc <= 1'b0;
        end else if (accept) begin
            idx <= close ? '0 : idx + IDX_W'(1);
            if (close) begin
                out_len   <= LEN_W'(idx) + LEN_W'(1);
                out_trunc <= ~in_last & (idx == LAST_IDX);
            end
        end
    end

    // Slot storage; unwritten slots of a short frame stay zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++)
                slot[k] <= '0;
        end else if (release_frame) begin
            for (int k = 0; k < N; k++)
                slot[k] <= '0;
        end else if (accept) begin
            slot[idx] <= in_data;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign out_array[k*W +: W] = slot[k];
    end

    array_acc_unit #(
        .W     (W),
        .SUM_W (SUM_W)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (release_frame),
        .en      (accept),
        .din     (in_data),
        .acc_sum (out_sum),
        .acc_max (out_max)
    );

endmodule

// File: tb/tb_array_stream_collector.sv
// Directed bench for array_stream_collector with N=8, W=8.
module tb_array_stream_collector;

    localparam int W     = 8;
    localparam int N     = 8;
    localparam int SUM_W = 11;
    localparam int LEN_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [N*W-1:0]   out_array;
    logic [LEN_W-1:0] out_len;
    logic [SUM_W-1:0] out_sum;
    logic [W-1:0]     out_max;
    logic             out_trunc;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    array_stream_collector #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_array (out_array),
        .out_len   (out_len),
        .out_sum   (out_sum),
        .out_max   (out_max),
        .out_trunc (out_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] v, input logic last);
        in_valid = 1'b1;
        in_data  = v;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 'x;
    endtask

    task automatic chk_full(input string tag);
        chk({tag, "_vld"},   64'(out_valid), 64'd1);
        chk({tag, "_array"}, out_array,      64'h0807060504030201);
        chk({tag, "_len"},   64'(out_len),   64'd8);
        chk({tag, "_sum"},   64'(out_sum),   64'd36);
        chk({tag, "_max"},   64'(out_max),   64'd8);
        chk({tag, "_trunc"}, 64'(out_trunc), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_array",     out_array,      64'd0);
        chk("rst_len",       64'(out_len),   64'd0);
        chk("rst_sum",       64'(out_sum),   64'd0);
        chk("rst_max",       64'(out_max),   64'd0);
        chk("rst_trunc",     64'(out_trunc), 64'd0);
        rst_n = 1'b1;
        step();

        // Full frame 1..8 with in_last on the eighth element.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(W'(i), i == 8);
            if (i < 8) chk("full_vld_early", 64'(out_valid), 64'd0);
        end
        chk_full("full");
        step();
        chk("full_rel_vld",   64'(out_valid), 64'd0);
        chk("full_rel_ready", 64'(in_ready),  64'd1);
        chk("full_rel_sum",   64'(out_sum),   64'd0);
        chk("full_rel_array", out_array,      64'd0);

        // Short frame 5, 200, 7.
        out_ready = 1'b0;
        send(8'd5, 1'b0);
        send(8'd200, 1'b0);
        send(8'd7, 1'b1);
        chk("short_vld",   64'(out_valid), 64'd1);
        chk("short_len",   64'(out_len),   64'd3);
        chk("short_sum",   64'(out_sum),   64'd212);
        chk("short_max",   64'(out_max),   64'd200);
        chk("short_array", out_array,      64'h0000000000_07C805);
        chk("short_trunc", 64'(out_trunc), 64'd0);
        out_ready = 1'b1;
        step();
        chk("short_rel_vld", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Truncated frame of 255s, then a 4-cycle stall with a pending element.
        for (int i = 0; i < 8; i++) send(8'd255, 1'b0);
        chk("trunc_vld",   64'(out_valid), 64'd1);
        chk("trunc_sum",   64'(out_sum),   64'd2040);
        chk("trunc_max",   64'(out_max),   64'd255);
        chk("trunc_flag",  64'(out_trunc), 64'd1);
        chk("trunc_len",   64'(out_len),   64'd8);
        chk("trunc_array", out_array,      64'hFFFFFFFFFFFFFFFF);
        in_valid = 1'b1;
        in_data  = 8'd1;
        in_last  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("stall_vld",   64'(out_valid), 64'd1);
            chk("stall_ready", 64'(in_ready),  64'd0);
            chk("stall_sum",   64'(out_sum),   64'd2040);
            chk("stall_trunc", 64'(out_trunc), 64'd1);
            chk("stall_array", out_array,      64'hFFFFFFFFFFFFFFFF);
        end
        out_ready = 1'b1;
        step();
        chk("hs_vld",   64'(out_valid), 64'd0);
        chk("hs_ready", 64'(in_ready),  64'd1);
        chk("hs_sum",   64'(out_sum),   64'd0);
        chk("hs_trunc", 64'(out_trunc), 64'd0);
        step();
        chk("held_elem_sum", 64'(out_sum), 64'd1);
        in_valid = 1'b0;
        in_data  = 'x;
        for (int i = 2; i <= 8; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) step();
            send(W'(i), i == 8);
            if (i < 8) chk("gap_vld_early", 64'(out_valid), 64'd0);
        end
        chk_full("gap");
        step();
        chk("gap_rel_vld", 64'(out_valid), 64'd0);

        // Asynchronous reset after three accepts discards the partial frame.
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(in_ready),  64'd1);
        chk("arst_vld",   64'(out_valid), 64'd0);
        chk("arst_sum",   64'(out_sum),   64'd0);
        chk("arst_max",   64'(out_max),   64'd0);
        chk("arst_array", out_array,      64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_idle_vld", 64'(out_valid), 64'd0);
        for (int i = 1; i <= 8; i++) begin
            send(W'(i), i == 8);
            if (i < 8) chk("arst_no_pulse", 64'(out_valid), 64'd0);
        end
        chk_full("after_rst");
        step();

        // Single-element frame.
        send(8'd9, 1'b1);
        chk("single_vld",   64'(out_valid), 64'd1);
        chk("single_len",   64'(out_len),   64'd1);
        chk("single_sum",   64'(out_sum),   64'd9);
        chk("single_max",   64'(out_max),   64'd9);
        chk("single_array", out_array,      64'd9);
        chk("single_trunc", 64'(out_trunc), 64'd0);
        step();
        chk("single_rel_vld", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
